// File: rtl/mux_nw_seq.sv
// mux_nw_seq: registered N-input, W-bit mux with an internal static/counting/LFSR select.
// Define MUX_PARITY_EN to add a registered parity output alongside q.
module mux_nw_seq #(
  parameter int WIDTH = 4,
  parameter int NUM_IN = 4,
  parameter int INVERT = 1,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    sel_load,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_IN*WIDTH-1:0] din,
`ifdef MUX_PARITY_EN
  output logic                    parity,
`endif
  output logic [WIDTH-1:0]        q,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    valid
);
  logic [SEL_W-1:0] sel;
  logic [7:0] lfsr, lfsr_next;
  logic [WIDTH-1:0] ch [NUM_IN];
  logic [WIDTH-1:0] q_next;
  logic cap;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign ch[i] = din[i*WIDTH +: WIDTH];
  end
  assign q_next = (INVERT != 0) ? ~ch[sel] : ch[sel];
  assign cap = en && mode != 2'b11;
  // Galois right-shift, taps 8'hB8; never reaches zero from the nonzero seed
  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign sel_out = sel;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      sel <= '0;
      lfsr <= 8'hA5;
      valid <= 1'b0;
    end else begin
      valid <= cap;
      if (cap) q <= q_next;
      if (en && mode == 2'b10) lfsr <= lfsr_next;
      if (en) sel <= sel_load ? sel_in : mode == 2'b01 ? sel + 1'b1 : mode == 2'b10 ? lfsr_next[SEL_W-1:0] : sel;
    end
`ifdef MUX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) parity <= 1'b0;
    else if (cap) parity <= ^q_next;
`endif
endmodule

// File: tb/tb_mux_nw_seq.sv
// tb_mux_nw_seq: directed test-plan checks plus randomized run against a behavioural model.
// Two instances share stimulus: INVERT=1 (dut) and INVERT=0 (dut0, carries parity when enabled).
module tb_mux_nw_seq;
  logic clk = 0, rst = 1, en = 0, sel_load = 0;
  logic [1:0] mode = 0, sel_in = 0;
  logic [15:0] din = 16'hDCBA;
  logic [3:0] q, q0;
  logic [1:0] sel_out, sel_out0;
  logic valid, valid0;
`ifdef MUX_PARITY_EN
  logic parity;
`endif
  int pass_n = 0, tot_n = 0;
  int m_q = 0, m_q0 = 0, m_sel = 0, m_lfsr = 8'hA5, m_valid = 0, m_par = 0;

  always #5 clk = ~clk;

  mux_nw_seq #(.WIDTH(4), .NUM_IN(4), .INVERT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_load(sel_load), .sel_in(sel_in),
    .din(din), .q(q), .sel_out(sel_out), .valid(valid));

  mux_nw_seq #(.WIDTH(4), .NUM_IN(4), .INVERT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_load(sel_load), .sel_in(sel_in),
    .din(din),
`ifdef MUX_PARITY_EN
    .parity(parity),
`endif
    .q(q0), .sel_out(sel_out0), .valid(valid0));

  task automatic check(input string name, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lfsr_step(input int x);
    return (x / 2) ^ ((x % 2 == 1) ? 184 : 0);
  endfunction

  function automatic int chan(input int d, input int s);
    return (d >> (4 * s)) % 16;
  endfunction

  // reference model: captures the pre-edge channel, then moves the select
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 0; m_q0 <= 0; m_sel <= 0; m_lfsr <= 8'hA5; m_valid <= 0; m_par <= 0;
    end else if (en) begin
      m_valid <= (mode != 3) ? 1 : 0;
      if (mode != 3) begin
        m_q <= 15 - chan(din, m_sel);
        m_q0 <= chan(din, m_sel);
        m_par <= $countones(chan(din, m_sel)) % 2;
      end
      if (sel_load) m_sel <= sel_in;
      else if (mode == 1) m_sel <= (m_sel + 1) % 4;
      else if (mode == 2) m_sel <= lfsr_step(m_lfsr) % 4;
      if (mode == 2) m_lfsr <= lfsr_step(m_lfsr);
    end else m_valid <= 0;
  end

  always @(negedge clk) begin
    check("model_q", q, m_q);
    check("model_q0", q0, m_q0);
    check("model_sel", sel_out, m_sel);
    check("model_sel0", sel_out0, m_sel);
    check("model_valid", valid, m_valid);
    check("model_valid0", valid0, m_valid);
`ifdef MUX_PARITY_EN
    check("model_parity", parity, m_par);
`endif
  end

  task automatic cyc(input logic e, input logic [1:0] m, input logic ld, input logic [1:0] si);
    en = e; mode = m; sel_load = ld; sel_in = si;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    #1;
    check("rst_q", q, 0);
    check("rst_valid", valid, 0);
    check("rst_sel", sel_out, 0);
    #1 rst = 0;
  endtask

  int exp_q[5], exp_s[5];

  initial begin
    repeat (2) @(negedge clk);
    check("reset_q", q, 0);
    check("reset_valid", valid, 0);
    check("reset_sel", sel_out, 0);
    rst = 0;
    // static select on channel 0
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check("static_q", q, 4'h5);
      check("static_valid", valid, 1);
      check("static_sel", sel_out, 0);
    end
    // counting select with wrap
    exp_q = '{5, 4, 3, 2, 5};
    exp_s = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0);
      check("count_q", q, exp_q[i]);
      check("count_sel", sel_out, exp_s[i]);
    end
    // load overrides counting; capture uses the old select
    cyc(1, 1, 1, 3);
    check("load_q", q, 4'h4);
    check("load_sel", sel_out, 3);
    cyc(1, 1, 0, 0);
    check("load_next_q", q, 4'h2);
    check("load_next_sel", sel_out, 0);
    // LFSR select from reset: EA,75,82,41
    pulse_rst();
    exp_q = '{5, 3, 4, 3, 0};
    exp_s = '{2, 1, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2, 0, 0);
      check("lfsr_q", q, exp_q[i]);
      check("lfsr_sel", sel_out, exp_s[i]);
      check("lfsr_valid", valid, 1);
    end
    // enable gating, hold mode, then async reset mid-cycle
    pulse_rst();
    cyc(1, 1, 0, 0);
    check("en1_q", q, 5); check("en1_valid", valid, 1); check("en1_sel", sel_out, 1);
    cyc(0, 1, 0, 0);
    check("en0_q", q, 5); check("en0_valid", valid, 0); check("en0_sel", sel_out, 1);
    cyc(1, 1, 0, 0);
    check("en1b_q", q, 4); check("en1b_valid", valid, 1); check("en1b_sel", sel_out, 2);
    cyc(1, 3, 0, 0);
    check("hold_q", q, 4); check("hold_valid", valid, 0); check("hold_sel", sel_out, 2);
    pulse_rst();
    check("rst_q0", q0, 0);
    // non-inverting instance with parity
    cyc(1, 0, 1, 2);
    cyc(1, 0, 0, 0);
    check("noinv_q_c", q0, 4'hC);
`ifdef MUX_PARITY_EN
    check("parity_c", parity, 0);
`endif
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 0);
    check("noinv_q_b", q0, 4'hB);
`ifdef MUX_PARITY_EN
    check("parity_b", parity, 1);
`endif
    // randomized run, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      sel_load = ($urandom_range(0, 5) == 0);
      sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) din = 16'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        #2 rst = 1;
        #2 rst = 0;
      end
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
